// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types used by the branch predictor.
package lc3b_types;

   // Why the resolve stage squashed the younger instructions.
   typedef enum logic [1:0] {
      RR_NONE   = 2'd0,
      RR_DIR    = 2'd1,
      RR_TARGET = 2'd2
   } redirect_reason_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter with optional parallel load; load wins over inc/dec.
module sat_counter #(
   parameter int           W       = 2,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] value
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               value <= RST_VAL;
      else if (load)            value <= load_val;
      else if (inc && !(&value)) value <= value + W'(1);
      else if (dec && (|value))  value <= value - W'(1);
   end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped dynamic branch predictor with WB-stage mispredict resolution,
// table training and saturating branch/mispredict statistics.
module branch_predict_unit
   import lc3b_types::*;
#(
   parameter int INDEX_BITS = 4,
   parameter int CNT_BITS   = 2,
   parameter int STAT_BITS  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 predict_en,
   input  logic [15:0]          fetch_pc,
   output logic                 predict_taken,
   output logic [15:0]          predict_target,
   input  logic                 resolve_valid,
   input  logic [15:0]          resolve_pc,
   input  logic [15:0]          resolve_pc_plus2,
   input  logic                 resolve_pred_taken,
   input  logic [15:0]          resolve_pred_target,
   input  logic                 resolve_taken,
   input  logic [15:0]          resolve_target,
   output logic                 flush_all,
   output logic [15:0]          redirect_pc,
   output logic [STAT_BITS-1:0] branch_count,
   output logic [STAT_BITS-1:0] mispredict_count
);

   localparam int                  TAG_BITS = 15 - INDEX_BITS;
   localparam int                  ENTRIES  = 1 << INDEX_BITS;
   localparam logic [CNT_BITS-1:0] WEAK_T   = CNT_BITS'(1) << (CNT_BITS - 1);
   localparam logic [CNT_BITS-1:0] WEAK_NT  = WEAK_T - CNT_BITS'(1);

   typedef struct packed {
      logic                valid;
      logic [TAG_BITS-1:0] tag;
      logic [CNT_BITS-1:0] cnt;
      logic [15:0]         target;
   } bpu_entry_t;

   logic [ENTRIES-1:0]                valid;
   logic [ENTRIES-1:0][TAG_BITS-1:0]  tags;
   logic [ENTRIES-1:0][CNT_BITS-1:0]  cnts;
   logic [ENTRIES-1:0][15:0]          targets;

   logic [INDEX_BITS-1:0] f_idx, r_idx;
   logic [TAG_BITS-1:0]   f_tag, r_tag;
   bpu_entry_t            f_ent, r_ent;
   logic                  f_hit, r_hit;
   redirect_reason_e      reason;

   assign f_idx = fetch_pc[INDEX_BITS:1];
   assign f_tag = fetch_pc[15:INDEX_BITS+1];
   assign r_idx = resolve_pc[INDEX_BITS:1];
   assign r_tag = resolve_pc[15:INDEX_BITS+1];

   assign f_ent = '{valid: valid[f_idx], tag: tags[f_idx], cnt: cnts[f_idx], target: targets[f_idx]};
   assign r_ent = '{valid: valid[r_idx], tag: tags[r_idx], cnt: cnts[r_idx], target: targets[r_idx]};
   assign f_hit = f_ent.valid && (f_ent.tag == f_tag);
   assign r_hit = r_ent.valid && (r_ent.tag == r_tag);

   // Prediction sees pre-edge table contents; same-cycle training lands next cycle.
   assign predict_taken  = predict_en && f_hit && f_ent.cnt[CNT_BITS-1];
   assign predict_target = f_hit ? f_ent.target : 16'h0000;

   always_comb begin
      reason = RR_NONE;
      if (resolve_valid) begin
         if (resolve_pred_taken != resolve_taken)
            reason = RR_DIR;
         else if (resolve_taken && (resolve_pred_target != resolve_target))
            reason = RR_TARGET;
      end
   end

   assign flush_all   = (reason != RR_NONE);
   assign redirect_pc = (flush_all && resolve_taken) ? resolve_target : resolve_pc_plus2;

   // Taken resolves either refresh a hit's target or allocate over the slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid   <= '0;
         tags    <= '0;
         targets <= '0;
      end else if (resolve_valid && resolve_taken) begin
         valid[r_idx]   <= 1'b1;
         tags[r_idx]    <= r_tag;
         targets[r_idx] <= resolve_target;
      end
   end

   for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
      logic we;
      assign we = resolve_valid && (r_idx == INDEX_BITS'(i));
      sat_counter #(.W(CNT_BITS), .RST_VAL(WEAK_NT)) u_cnt (
         .clk      (clk),
         .rst_n    (rst_n),
         .load     (we && !r_hit && resolve_taken),
         .load_val (WEAK_T),
         .inc      (we && r_hit && resolve_taken),
         .dec      (we && r_hit && !resolve_taken),
         .value    (cnts[i])
      );
   end

   sat_counter #(.W(STAT_BITS)) u_branch_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (1'b0),
      .load_val ('0),
      .inc      (resolve_valid),
      .dec      (1'b0),
      .value    (branch_count)
   );

   sat_counter #(.W(STAT_BITS)) u_mispred_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (1'b0),
      .load_val ('0),
      .inc      (flush_all),
      .dec      (1'b0),
      .value    (mispredict_count)
   );

   // Instructions are halfword aligned, so pc[0] never selects anything.
   logic pc_lsb_unused;
   assign pc_lsb_unused = fetch_pc[0] ^ resolve_pc[0];

endmodule

// File: tb/tb_branch_predict_unit.sv
// Table-driven scoreboard bench for branch_predict_unit plus reset/saturation sequences.
module tb_branch_predict_unit;

   localparam int IB = 4;
   localparam int CB = 2;
   localparam int SB = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          predict_en;
   logic [15:0]   fetch_pc;
   logic          predict_taken;
   logic [15:0]   predict_target;
   logic          resolve_valid;
   logic [15:0]   resolve_pc;
   logic [15:0]   resolve_pc_plus2;
   logic          resolve_pred_taken;
   logic [15:0]   resolve_pred_target;
   logic          resolve_taken;
   logic [15:0]   resolve_target;
   logic          flush_all;
   logic [15:0]   redirect_pc;
   logic [SB-1:0] branch_count;
   logic [SB-1:0] mispredict_count;

   branch_predict_unit #(.INDEX_BITS(IB), .CNT_BITS(CB), .STAT_BITS(SB)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .predict_en          (predict_en),
      .fetch_pc            (fetch_pc),
      .predict_taken       (predict_taken),
      .predict_target      (predict_target),
      .resolve_valid       (resolve_valid),
      .resolve_pc          (resolve_pc),
      .resolve_pc_plus2    (resolve_pc_plus2),
      .resolve_pred_taken  (resolve_pred_taken),
      .resolve_pred_target (resolve_pred_target),
      .resolve_taken       (resolve_taken),
      .resolve_target      (resolve_target),
      .flush_all           (flush_all),
      .redirect_pc         (redirect_pc),
      .branch_count        (branch_count),
      .mispredict_count    (mispredict_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic en; logic [15:0] fpc;
      logic rv; logic [15:0] rpc; logic rpt; logic [15:0] rptgt; logic rt; logic [15:0] rtgt;
      logic xpt; logic [15:0] xptgt; logic xfl; logic [15:0] xred; int xbc; int xmc;
   } vec_t;

   typedef struct {
      logic pt; logic [15:0] ptgt; logic fl; logic [15:0] red; int bc; int mc;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic vec_t mkv(logic en, logic [15:0] fpc, logic rv, logic [15:0] rpc,
                                logic rpt, logic [15:0] rptgt, logic rt, logic [15:0] rtgt,
                                logic xpt, logic [15:0] xptgt, logic xfl, logic [15:0] xred,
                                int xbc, int xmc);
      vec_t v;
      v.en = en; v.fpc = fpc; v.rv = rv; v.rpc = rpc; v.rpt = rpt; v.rptgt = rptgt;
      v.rt = rt; v.rtgt = rtgt; v.xpt = xpt; v.xptgt = xptgt; v.xfl = xfl; v.xred = xred;
      v.xbc = xbc; v.xmc = xmc;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      predict_en          = v.en;
      fetch_pc            = v.fpc;
      resolve_valid       = v.rv;
      resolve_pc          = v.rpc;
      resolve_pc_plus2    = v.rpc + 16'd2;
      resolve_pred_taken  = v.rpt;
      resolve_pred_target = v.rptgt;
      resolve_taken       = v.rt;
      resolve_target      = v.rtgt;
   endtask

   task automatic apply(input vec_t v, input int k);
      exp_t e;
      drive(v);
      sb.push_back('{pt: v.xpt, ptgt: v.xptgt, fl: v.xfl, red: v.xred, bc: v.xbc, mc: v.xmc});
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("v%0d predict_taken", k),    32'(predict_taken),    32'(e.pt));
      chk($sformatf("v%0d predict_target", k),   32'(predict_target),   32'(e.ptgt));
      chk($sformatf("v%0d flush_all", k),        32'(flush_all),        32'(e.fl));
      chk($sformatf("v%0d redirect_pc", k),      32'(redirect_pc),      32'(e.red));
      chk($sformatf("v%0d branch_count", k),     32'(branch_count),     32'(e.bc));
      chk($sformatf("v%0d mispredict_count", k), 32'(mispredict_count), 32'(e.mc));
      @(posedge clk);
      #1;
   endtask

   initial begin
      // en  fpc     rv rpc     rpt rptgt   rt rtgt     xpt xptgt   xfl xred     bc  mc
      vecs.push_back(mkv(1, 16'h40, 0, 16'h40, 0, 16'h0,   0, 16'h0,   0, 16'h0,   0, 16'h42,  0, 0));
      vecs.push_back(mkv(1, 16'h40, 1, 16'h40, 0, 16'h0,   1, 16'h100, 0, 16'h0,   1, 16'h100, 0, 0));
      vecs.push_back(mkv(1, 16'h40, 0, 16'h40, 0, 16'h0,   0, 16'h0,   1, 16'h100, 0, 16'h42,  1, 1));
      vecs.push_back(mkv(1, 16'h40, 1, 16'h40, 1, 16'h100, 0, 16'h0,   1, 16'h100, 1, 16'h42,  1, 1));
      vecs.push_back(mkv(1, 16'h40, 1, 16'h40, 0, 16'h0,   0, 16'h0,   0, 16'h100, 0, 16'h42,  2, 2));
      vecs.push_back(mkv(1, 16'h40, 1, 16'h40, 0, 16'h0,   1, 16'h100, 0, 16'h100, 1, 16'h100, 3, 2));
      vecs.push_back(mkv(1, 16'h40, 1, 16'h40, 0, 16'h0,   1, 16'h100, 0, 16'h100, 1, 16'h100, 4, 3));
      vecs.push_back(mkv(1, 16'h40, 1, 16'h40, 1, 16'h100, 1, 16'h200, 1, 16'h100, 1, 16'h200, 5, 4));
      vecs.push_back(mkv(1, 16'h40, 0, 16'h40, 0, 16'h0,   0, 16'h0,   1, 16'h200, 0, 16'h42,  6, 5));
      vecs.push_back(mkv(1, 16'h40, 1, 16'h40, 1, 16'h200, 1, 16'h200, 1, 16'h200, 0, 16'h42,  6, 5));
      // aliasing: 0x0060 shares index 0 with 0x0040
      vecs.push_back(mkv(1, 16'h60, 1, 16'h60, 0, 16'h0,   1, 16'h300, 0, 16'h0,   1, 16'h300, 7, 5));
      vecs.push_back(mkv(1, 16'h40, 0, 16'h40, 0, 16'h0,   0, 16'h0,   0, 16'h0,   0, 16'h42,  8, 6));
      vecs.push_back(mkv(1, 16'h60, 0, 16'h40, 0, 16'h0,   0, 16'h0,   1, 16'h300, 0, 16'h42,  8, 6));
      // miss + not taken leaves the table alone
      vecs.push_back(mkv(1, 16'h60, 1, 16'h80, 0, 16'h0,   0, 16'h0,   1, 16'h300, 0, 16'h82,  8, 6));
      vecs.push_back(mkv(1, 16'h60, 0, 16'h40, 0, 16'h0,   0, 16'h0,   1, 16'h300, 0, 16'h42,  9, 6));
      // static mode
      vecs.push_back(mkv(0, 16'h60, 0, 16'h40, 0, 16'h0,   0, 16'h0,   0, 16'h300, 0, 16'h42,  9, 6));
      vecs.push_back(mkv(0, 16'h60, 1, 16'h60, 0, 16'h0,   1, 16'h300, 0, 16'h300, 1, 16'h300, 9, 6));

      rst_n = 1'b0;
      drive(mkv(1, 16'h40, 0, 16'h40, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 0));
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int k = 0; k < vecs.size(); k++) apply(vecs[k], k);

      // Statistics saturation: 2**SB+5 correctly predicted not-taken resolves.
      drive(mkv(1, 16'h60, 1, 16'h80, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 0));
      repeat ((1 << SB) + 5) begin
         @(posedge clk);
         #1;
      end
      apply(mkv(1, 16'h60, 0, 16'h40, 0, 16'h0, 0, 16'h0, 1, 16'h300, 0, 16'h42, (1 << SB) - 1, 7), 100);

      // Asynchronous reset mid-stream with a taken resolve pending.
      drive(mkv(1, 16'h60, 1, 16'h40, 0, 16'h0, 1, 16'h500, 0, 16'h0, 0, 16'h0, 0, 0));
      #1 rst_n = 1'b0;
      #1;
      chk("rst predict_taken",    32'(predict_taken),    32'h0);
      chk("rst predict_target",   32'(predict_target),   32'h0);
      chk("rst branch_count",     32'(branch_count),     32'h0);
      chk("rst mispredict_count", 32'(mispredict_count), 32'h0);
      chk("rst flush_all",        32'(flush_all),        32'h1);
      chk("rst redirect_pc",      32'(redirect_pc),      32'h500);
      @(posedge clk);
      #1 rst_n = 1'b1;
      apply(mkv(1, 16'h40, 0, 16'h40, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 16'h42, 0, 0), 200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
Dynamic branch predictor and misprediction resolver for the LC-3b pipeline; successor to the static flush logic. At fetch it indexes a direct-mapped table of saturating counters plus target addresses and returns a taken/target prediction. At WB it compares the branch's prediction against the actual outcome, raises a flush and redirect PC on mismatch, and trains the table. Also keeps saturating branch and mispredict statistics counters.

Parameters:
INDEX_BITS, 4, table has 2**INDEX_BITS entries, indexed by pc[INDEX_BITS:1]
CNT_BITS, 2, width of each saturating direction counter (>=1)
STAT_BITS, 16, width of each statistics counter
TAG_BITS, 15-INDEX_BITS, derived (localparam); tag = pc[15:INDEX_BITS+1]

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
predict_en  in  1  1 = dynamic prediction; 0 = static not-taken mode
fetch_pc  in  16  PC of the instruction in fetch
predict_taken  out  1  prediction for fetch_pc
predict_target  out  16  predicted target; valid when predict_taken=1
resolve_valid  in  1  a branch/jump is in WB this cycle
resolve_pc  in  16  PC of the resolving branch
resolve_pc_plus2  in  16  fall-through PC of the resolving branch
resolve_pred_taken  in  1  prediction that was carried down the pipe
resolve_pred_target  in  16  predicted target carried down the pipe
resolve_taken  in  1  actual outcome (pcmux select non-zero)
resolve_target  in  16  actual target (pcmux output)
flush_all  out  1  squash all younger instructions this cycle
redirect_pc  out  16  PC to load when flush_all=1
branch_count  out  STAT_BITS  resolved branches, saturating
mispredict_count  out  STAT_BITS  mispredicts, saturating

Behaviour:
- Entry fields: valid, tag[TAG_BITS], cnt[CNT_BITS], target[16].
- Prediction (combinational from current table state): hit = valid & tag match; predict_taken = predict_en & hit & cnt[MSB]; predict_target = entry target (0 on miss).
- Mispredict (combinational, same cycle as resolve_valid): resolve_valid & ((resolve_pred_taken != resolve_taken) | (resolve_pred_taken & resolve_taken & resolve_pred_target != resolve_target)).
- flush_all = mispredict. redirect_pc = resolve_taken ? resolve_target : resolve_pc_plus2. When flush_all=0, redirect_pc = resolve_pc_plus2 (don't-care for the consumer, but must be deterministic).
- Training (rising edge, resolve_valid=1, independent of predict_en):
  - Hit: cnt +1 if taken and -1 if not taken, saturating at all-ones/zero. If taken, target <= resolve_target.
  - Miss and taken: allocate (overwrite): valid=1, tag, target=resolve_target, cnt=WEAK_T=1<<(CNT_BITS-1).
  - Miss and not taken: no change.
- Same-cycle fetch and update to the same entry: prediction uses pre-edge contents; the write becomes visible next cycle.
- Stats: branch_count +1 on each resolve_valid; mispredict_count +1 on each flush_all; both hold at all-ones.
- Reset (asynchronous, rst_n=0): all valid=0; cnt=WEAK_NT=(1<<(CNT_BITS-1))-1; targets and tags 0; both stats 0. Outputs during reset: predict_taken=0, predict_target=0, and flush_all follows the resolve inputs. Reset mid-training discards the pending write.
- CNT_BITS=1: WEAK_NT=0, WEAK_T=1 (last-outcome predictor).
- predict_en=0 gives reference static behaviour: never predicts taken, and flush occurs on every taken branch.

Decomposition:
- lc3b_types package: add bpu_entry_t struct (valid/tag/cnt/target). The package parameterises it with widths or declares it locally as a packed struct with parameterised widths. Add redirect reason enum if needed.
- One sub-module, sat_counter (parametrised width, inc/dec/hold, saturating), reused for table counters and statistics.

Test Plan:
- Reset, fetch_pc=0x0040 -> predict_taken=0, predict_target=0x0000, both counts 0.
- Resolve pc=0x0040 taken target=0x0100, pred_taken=0 -> flush_all=1, redirect_pc=0x0100. Next cycle fetch 0x0040 -> predict_taken=1, target=0x0100, mispredict_count=1.
- Same branch resolved not-taken twice, pred_taken=1 -> first flush, redirect_pc=pc_plus2=0x0042. Counter goes 10->01->00. Predict_taken=0 after the first update.
- Resolve pred_taken=1 target 0x0100, actual taken target 0x0200 -> flush_all=1, redirect_pc=0x0200, entry target updated to 0x0200.
- Aliasing: allocate 0x0040, then resolve taken 0x0060 (INDEX_BITS=4, same index 0, different tag) -> 0x0040 now misses, 0x0060 hits.
- predict_en=0 with trained entry -> predict_taken=0. Drive 2**STAT_BITS+5 resolves -> branch_count holds at all-ones. Assert rst_n mid-stream -> table and counts cleared immediately.
